// File: rtl/ntt_butterfly_engine_pkg.sv
// Shared parameters and phase encoding for the NTT butterfly engine.
package ntt_pkg;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned MODULUS = 12289;

    typedef enum logic [1:0] {
        RD_LO = 2'd0,
        RD_HI = 2'd1,
        WR_LO = 2'd2,
        WR_HI = 2'd3
    } phase_t;

endpackage

// File: rtl/ntt_butterfly_engine_if.sv
// Generator-stream and coefficient-RAM signals seen by the butterfly engine.
interface ntt_butterfly_engine_if #(
    parameter int unsigned ADDR_W = ntt_pkg::ADDR_W,
    parameter int unsigned DATA_W = ntt_pkg::DATA_W
);

    logic              en;
    logic [ADDR_W-1:0] addr_in;
    logic              wr_mode_in;
    logic [DATA_W-1:0] twiddle;
    logic [ADDR_W-1:0] mem_raddr;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              bfly_done;
    logic              seq_err;

    modport master (
        output en, addr_in, wr_mode_in, twiddle, mem_rdata,
        input  mem_raddr, mem_re, mem_we, mem_waddr, mem_wdata, bfly_done, seq_err
    );

    modport slave (
        input  en, addr_in, wr_mode_in, twiddle, mem_rdata,
        output mem_raddr, mem_re, mem_we, mem_waddr, mem_wdata, bfly_done, seq_err
    );

endinterface

// File: rtl/ntt_butterfly_engine_mod_mult.sv
// Combinational modular multiply: p = (a * b) mod MODULUS on a full-width product.
module ntt_mod_mult #(
    parameter int unsigned DATA_W  = ntt_pkg::DATA_W,
    parameter int unsigned MODULUS = ntt_pkg::MODULUS
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] p
);

    localparam logic [2*DATA_W-1:0] Q = (2*DATA_W)'(MODULUS);

    logic [2*DATA_W-1:0] prod;

    always_comb begin
        prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        p    = DATA_W'(prod % Q);
    end

endmodule

// File: rtl/ntt_butterfly_engine.sv
// One Cooley-Tukey butterfly per four en slots (rd lo, rd hi, wr lo, wr hi)
// against a simple dual-port coefficient RAM with 1-cycle read latency.
module ntt_butterfly_engine
    import ntt_pkg::*;
#(
    parameter int unsigned ADDR_W  = ntt_pkg::ADDR_W,
    parameter int unsigned DATA_W  = ntt_pkg::DATA_W,
    parameter int unsigned MODULUS = ntt_pkg::MODULUS
) (
    input  logic                  clk,
    input  logic                  rst,
    ntt_butterfly_engine_if.slave bus
);

    localparam logic [DATA_W:0]   Q_WIDE = (DATA_W+1)'(MODULUS);
    localparam logic [DATA_W-1:0] Q      = DATA_W'(MODULUS);

    phase_t            phase, phaseNext;
    logic              slotRdLo, slotRdHi, slotWrLo, slotWrHi;
    logic              rdLoPend, rdHiPend, pendWr, seqErr;
    logic [DATA_W-1:0] regA, regB, regW, yReg;
    logic [DATA_W-1:0] prodP, resX, resY;
    logic [DATA_W:0]   sum;
    logic [ADDR_W-1:0] wlo, whi;

    ntt_mod_mult #(.DATA_W(DATA_W), .MODULUS(MODULUS)) uMult (
        .a (regW),
        .b (regB),
        .p (prodP)
    );

    always_comb begin
        phaseNext = phase;
        if (bus.en) begin
            case (phase)
                RD_LO:   phaseNext = RD_HI;
                RD_HI:   phaseNext = WR_LO;
                WR_LO:   phaseNext = WR_HI;
                default: phaseNext = RD_LO;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) phase <= RD_LO;
        else     phase <= phaseNext;
    end

    assign slotRdLo = bus.en && (phase == RD_LO);
    assign slotRdHi = bus.en && (phase == RD_HI);
    assign slotWrLo = bus.en && (phase == WR_LO);
    assign slotWrHi = bus.en && (phase == WR_HI);

    // Operand differences wrap mod 2**DATA_W; adding q on borrow lands back in [0, q).
    always_comb begin
        sum  = {1'b0, regA} + {1'b0, prodP};
        resX = (sum >= Q_WIDE) ? DATA_W'(sum - Q_WIDE) : DATA_W'(sum);
        resY = regA - prodP + ((regA < prodP) ? Q : '0);
    end

    // Read data is captured on the edge after each read, independent of en stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdLoPend <= 1'b0;
            rdHiPend <= 1'b0;
            pendWr   <= 1'b0;
            seqErr   <= 1'b0;
            regA     <= '0;
            regB     <= '0;
            regW     <= '0;
            yReg     <= '0;
            wlo      <= '0;
            whi      <= '0;
        end else begin
            rdLoPend <= slotRdLo;
            rdHiPend <= slotRdHi;
            pendWr   <= slotWrHi;
            if (rdLoPend) regA <= bus.mem_rdata;
            if (rdHiPend) regB <= bus.mem_rdata;
            if (slotRdHi) regW <= bus.twiddle;
            if (slotWrLo) wlo  <= bus.addr_in;
            if (slotWrHi) begin
                whi  <= bus.addr_in;
                yReg <= resY;
            end
            if (bus.en && (bus.wr_mode_in != phase[1])) seqErr <= 1'b1;
        end
    end

    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_waddr = '0;
        bus.mem_wdata = '0;
        bus.bfly_done = 1'b0;
        if (!rst) begin
            if (pendWr) begin
                bus.mem_we    = 1'b1;
                bus.mem_waddr = whi;
                bus.mem_wdata = yReg;
                bus.bfly_done = 1'b1;
            end else if (slotWrHi) begin
                bus.mem_we    = 1'b1;
                bus.mem_waddr = wlo;
                bus.mem_wdata = resX;
            end
        end
    end

    assign bus.mem_raddr = bus.addr_in;
    assign bus.mem_re    = !rst && bus.en && !phase[1];
    assign bus.seq_err   = seqErr;

endmodule

// File: tb/tb_ntt_butterfly_engine.sv
// Directed bench for ntt_butterfly_engine: vector table plus stall/chain/error/reset sequences.
module tb_ntt_butterfly_engine;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 16;
    localparam logic [DW-1:0] JUNK = 16'd999;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] w;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [DW-1:0] nextRd;
    vec_t vecs [6];

    ntt_butterfly_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ntt_butterfly_engine #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MODULUS (12289)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic e, input int a, input logic wr, input logic [DW-1:0] tw);
        bus.en         = e;
        bus.addr_in    = AW'(a);
        bus.wr_mode_in = wr;
        bus.twiddle    = tw;
        bus.mem_rdata  = nextRd;
        nextRd         = JUNK;
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1023, 1'b0, JUNK);
            @(negedge clk);
            chk("stall_we", 32'(bus.mem_we), 0);
            chk("stall_re", 32'(bus.mem_re), 0);
            nextCycle;
        end
    endtask

    task automatic quad(input vec_t v, input int lo, input int hi, input int st,
                        input bit skip0, input bit chain, input int nextLo, input bit badWr);
        if (!skip0) begin
            drive(1'b1, lo, badWr, JUNK);
            @(negedge clk);
            chk("s0_re", 32'(bus.mem_re), 1);
            chk("s0_raddr", 32'(bus.mem_raddr), 32'(lo));
            chk("s0_we", 32'(bus.mem_we), 0);
            nextCycle;
        end
        nextRd = v.a;
        stall(st);
        drive(1'b1, hi, 1'b0, v.w);
        @(negedge clk);
        chk("s1_re", 32'(bus.mem_re), 1);
        chk("s1_raddr", 32'(bus.mem_raddr), 32'(hi));
        nextCycle;
        nextRd = v.b;
        stall(st);
        drive(1'b1, lo, 1'b1, JUNK);
        @(negedge clk);
        chk("s2_re", 32'(bus.mem_re), 0);
        chk("s2_we", 32'(bus.mem_we), 0);
        nextCycle;
        stall(st);
        drive(1'b1, hi, 1'b1, JUNK);
        @(negedge clk);
        chk("x_we", 32'(bus.mem_we), 1);
        chk("x_waddr", 32'(bus.mem_waddr), 32'(lo));
        chk("x_wdata", 32'(bus.mem_wdata), 32'(v.x));
        chk("x_done", 32'(bus.bfly_done), 0);
        nextCycle;
        if (chain) drive(1'b1, nextLo, 1'b0, JUNK);
        else       drive(1'b0, 1023, 1'b0, JUNK);
        @(negedge clk);
        chk("y_we", 32'(bus.mem_we), 1);
        chk("y_waddr", 32'(bus.mem_waddr), 32'(hi));
        chk("y_wdata", 32'(bus.mem_wdata), 32'(v.y));
        chk("y_done", 32'(bus.bfly_done), 1);
        if (chain) chk("chain_re", 32'(bus.mem_re), 1);
        nextCycle;
        if (!chain) begin
            drive(1'b0, 1023, 1'b0, JUNK);
            @(negedge clk);
            chk("idle_we", 32'(bus.mem_we), 0);
            chk("idle_done", 32'(bus.bfly_done), 0);
            nextCycle;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{a: 16'd5,     b: 16'd7,     w: 16'd3,     x: 16'd26,    y: 16'd12273};
        vecs[1] = '{a: 16'd12288, b: 16'd1,     w: 16'd1,     x: 16'd0,     y: 16'd12287};
        vecs[2] = '{a: 16'd0,     b: 16'd12288, w: 16'd12288, x: 16'd1,     y: 16'd12288};
        vecs[3] = '{a: 16'd100,   b: 16'd200,   w: 16'd300,   x: 16'd10944, y: 16'd1545};
        vecs[4] = '{a: 16'd12288, b: 16'd12288, w: 16'd12288, x: 16'd0,     y: 16'd12287};
        vecs[5] = '{a: 16'd1234,  b: 16'd5678,  w: 16'd4321,  x: 16'd7028,  y: 16'd7729};

        nextRd = JUNK;
        rst    = 1'b1;
        drive(1'b0, 0, 1'b0, '0);
        nextCycle;
        nextCycle;
        @(negedge clk);
        chk("rst_we", 32'(bus.mem_we), 0);
        chk("rst_re", 32'(bus.mem_re), 0);
        chk("rst_done", 32'(bus.bfly_done), 0);
        chk("rst_seqerr", 32'(bus.seq_err), 0);
        chk("rst_waddr", 32'(bus.mem_waddr), 0);
        chk("rst_wdata", 32'(bus.mem_wdata), 0);
        nextCycle;
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            quad(vecs[i], i * 2, i * 2 + 512, 0, 1'b0, 1'b0, 0, 1'b0);
        chk("seqerr_clean", 32'(bus.seq_err), 0);

        // Stalls between slots: captured values and phase must hold.
        quad(vecs[0], 20, 532, 3, 1'b0, 1'b0, 0, 1'b0);
        quad(vecs[5], 22, 534, 2, 1'b0, 1'b0, 0, 1'b0);

        // Y write coinciding with the next quad's slot-0 read.
        quad(vecs[3], 30, 542, 0, 1'b0, 1'b1, 32, 1'b0);
        quad(vecs[1], 32, 544, 0, 1'b1, 1'b0, 0, 1'b0);

        // Wrong wr_mode in slot 0: sticky error, engine follows its own phase.
        quad(vecs[2], 40, 552, 0, 1'b0, 1'b0, 0, 1'b1);
        chk("seqerr_set", 32'(bus.seq_err), 1);
        quad(vecs[0], 42, 554, 0, 1'b0, 1'b0, 0, 1'b0);
        chk("seqerr_sticky", 32'(bus.seq_err), 1);

        // Reset in slot 2: quad abandoned, no writes, restart at RD_LO.
        drive(1'b1, 50, 1'b0, JUNK);
        nextCycle;
        nextRd = vecs[3].a;
        drive(1'b1, 562, 1'b0, vecs[3].w);
        nextCycle;
        nextRd = vecs[3].b;
        rst = 1'b1;
        drive(1'b1, 50, 1'b1, JUNK);
        @(negedge clk);
        chk("rstmid_we", 32'(bus.mem_we), 0);
        nextCycle;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 562, 1'b1, JUNK);
            @(negedge clk);
            chk("postrst_we", 32'(bus.mem_we), 0);
            chk("postrst_done", 32'(bus.bfly_done), 0);
            nextCycle;
        end
        chk("postrst_seqerr", 32'(bus.seq_err), 0);
        quad(vecs[4], 60, 572, 0, 1'b0, 1'b0, 0, 1'b0);
        chk("restart_seqerr", 32'(bus.seq_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
